// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-message layout and client identifiers for the two-client memory arbiter.
// Message widths depend on the opaque field width, so helper functions size the flat ports.
package mem_req_arbiter_pkg;

  typedef enum logic [2:0] {
    MEM_READ    = 3'd0,
    MEM_WRITE   = 3'd1,
    MEM_INIT    = 3'd2,
    MEM_AMO_ADD = 3'd3
  } mem_type_e;

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_id_e;

  localparam int unsigned MEM_TYPE_BITS = 3;
  localparam int unsigned MEM_ADDR_BITS = 32;
  localparam int unsigned MEM_LEN_BITS  = 2;
  localparam int unsigned MEM_DATA_BITS = 32;
  localparam int unsigned MEM_TEST_BITS = 2;

  // Request: {type, opaque, addr, len, data}
  function automatic int unsigned mem_req_bits(input int unsigned opaq_bits);
    return MEM_TYPE_BITS + opaq_bits + MEM_ADDR_BITS + MEM_LEN_BITS + MEM_DATA_BITS;
  endfunction

  // Response: {type, opaque, test, len, data}
  function automatic int unsigned mem_resp_bits(input int unsigned opaq_bits);
    return MEM_TYPE_BITS + opaq_bits + MEM_TEST_BITS + MEM_LEN_BITS + MEM_DATA_BITS;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_grant_order_fifo.sv
// Records which client owns each outstanding request, oldest entry at head.
// Latency: head is combinational from storage; push is refused when full, pop when empty.
module grant_order_fifo #(
  parameter int unsigned p_depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       push_id,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic                       head,
  output logic [$clog2(p_depth):0]   count
);

  localparam int unsigned PW = $clog2(p_depth);
  localparam int unsigned CW = PW + 1;

  logic [p_depth-1:0] slots;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(p_depth));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_id;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between two clients; zero added latency.
// Requests stall while the grant-order FIFO is full; responses stall on the owning client's resp_rdy.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned p_opaq_bits = 8,
  parameter int unsigned p_depth     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,

  input  logic                                   client0_req_val,
  output logic                                   client0_req_rdy,
  input  logic [mem_req_bits(p_opaq_bits)-1:0]   client0_req_msg,
  output logic                                   client0_resp_val,
  input  logic                                   client0_resp_rdy,
  output logic [mem_resp_bits(p_opaq_bits)-1:0]  client0_resp_msg,

  input  logic                                   client1_req_val,
  output logic                                   client1_req_rdy,
  input  logic [mem_req_bits(p_opaq_bits)-1:0]   client1_req_msg,
  output logic                                   client1_resp_val,
  input  logic                                   client1_resp_rdy,
  output logic [mem_resp_bits(p_opaq_bits)-1:0]  client1_resp_msg,

  output logic                                   mem_req_val,
  input  logic                                   mem_req_rdy,
  output logic [mem_req_bits(p_opaq_bits)-1:0]   mem_req_msg,
  input  logic                                   mem_resp_val,
  output logic                                   mem_resp_rdy,
  input  logic [mem_resp_bits(p_opaq_bits)-1:0]  mem_resp_msg
);

  localparam int unsigned CW = $clog2(p_depth) + 1;

  client_id_e      prio;
  client_id_e      winner;
  client_id_e      head;
  logic            head_bit;
  logic            full;
  logic            empty;
  logic            req_xfer;
  logic            resp_xfer;
  logic [CW-1:0]   count;

  always_comb begin
    winner = CLIENT0;
    if (client0_req_val & client1_req_val) begin
      winner = prio;
    end else if (client1_req_val) begin
      winner = CLIENT1;
    end
  end

  // Full blocks requests even when a pop lands in the same cycle, keeping resp->req free of comb paths.
  assign mem_req_val     = (client0_req_val | client1_req_val) & ~full;
  assign mem_req_msg     = (winner == CLIENT1) ? client1_req_msg : client0_req_msg;
  assign client0_req_rdy = client0_req_val & (winner == CLIENT0) & mem_req_rdy & ~full;
  assign client1_req_rdy = client1_req_val & (winner == CLIENT1) & mem_req_rdy & ~full;
  assign req_xfer        = mem_req_val & mem_req_rdy;

  assign head             = client_id_e'(head_bit);
  assign client0_resp_val = mem_resp_val & ~empty & (head == CLIENT0);
  assign client1_resp_val = mem_resp_val & ~empty & (head == CLIENT1);
  assign mem_resp_rdy     = ~empty & ((head == CLIENT1) ? client1_resp_rdy : client0_resp_rdy);
  assign resp_xfer        = mem_resp_val & mem_resp_rdy;
  assign client0_resp_msg = mem_resp_msg;
  assign client1_resp_msg = mem_resp_msg;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= CLIENT0;
    end else if (req_xfer) begin
      prio <= client_id_e'(~winner);
    end
  end

  grant_order_fifo #(
    .p_depth (p_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_xfer),
    .push_id (winner),
    .pop     (resp_xfer),
    .full    (full),
    .empty   (empty),
    .head    (head_bit),
    .count   (count)
  );

`ifndef SYNTHESIS
  function automatic string trace();
    string     g;
    string     r;
    mem_type_e t;
    t = mem_type_e'(mem_req_msg[mem_req_bits(p_opaq_bits)-1 -: MEM_TYPE_BITS]);
    g = req_xfer  ? $sformatf("req c%0d %s", winner, t.name()) : "req --";
    r = resp_xfer ? $sformatf("resp c%0d", head) : "resp --";
    return $sformatf("%s | %s | n=%0d", g, r, count);
  endfunction
`endif

endmodule
